// File: rtl/series_eval_if.sv
// series_eval_if: operand, coefficient-load and result handshake bundle for series_eval_engine.
interface series_eval_if #(
   parameter int W     = 16,
   parameter int TERMS = 8,
   parameter int G     = 2
);
   localparam int AW = $clog2(TERMS);
   localparam int NW = AW + 1;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  x_in;
   logic          alt_in;
   logic [NW-1:0] n_terms_in;
   logic          coef_we;
   logic [AW-1:0] coef_addr;
   logic [W-1:0]  coef_wdata;
   logic          out_valid;
   logic          out_ready;
   logic [W+G-1:0] y_out;
   logic          busy;
   modport master (
      output in_valid, x_in, alt_in, n_terms_in, coef_we, coef_addr, coef_wdata, out_ready,
      input  in_ready, out_valid, y_out, busy
   );
   modport slave (
      input  in_valid, x_in, alt_in, n_terms_in, coef_we, coef_addr, coef_wdata, out_ready,
      output in_ready, out_valid, y_out, busy
   );
endinterface

// File: rtl/series_eval_engine.sv
// series_eval_engine: fixed-point power-series evaluator, y = sum s_k*t_k with t_k = t_(k-1)*x*a_k,
// sharing one W x W multiplier between the x step (MULX) and the coefficient step (MULC).
module series_eval_engine #(
   parameter int W     = 16,
   parameter int TERMS = 8,
   parameter int G     = 2
) (
   input logic         clk,
   input logic         rst,
   series_eval_if.slave bus
);
   localparam int AW   = $clog2(TERMS);
   localparam int NW   = AW + 1;
   localparam int ACCW = W + G;
   localparam logic [W-1:0]    ONE_T = '1;
   localparam logic [ACCW-1:0] ONE_A = ACCW'(1) << W;
   typedef enum logic [1:0] {IDLE, MULX, MULC, DONE} state_t;
   state_t         state, state_nx;
   logic [W-1:0]   t, x, mul_b, tn;
   logic [W-1:0]   coef [TERMS];
   logic [ACCW-1:0] acc, acc_nx;
   logic [ACCW:0]  sum;
   logic [2*W-1:0] prod;
   logic [NW-1:0]  n, k, n_cl;
   logic           alt, sub;
   assign n_cl  = bus.n_terms_in == '0 ? NW'(1)
                : bus.n_terms_in > NW'(TERMS) ? NW'(TERMS) : bus.n_terms_in;
   assign mul_b = state == MULX ? x : coef[k[AW-1:0]];
   assign prod  = t * mul_b;
   assign tn    = prod[2*W-1:W];
   assign sub   = alt & k[0];
   // the extra top bit is a carry on add and a borrow on subtract; either clamps the accumulator
   assign sum    = sub ? {1'b0, acc} - {{(G+1){1'b0}}, tn} : {1'b0, acc} + {{(G+1){1'b0}}, tn};
   assign acc_nx = sum[ACCW] ? (sub ? '0 : '1) : sum[ACCW-1:0];
   assign bus.in_ready  = state == IDLE;
   assign bus.out_valid = state == DONE;
   assign bus.busy      = state == MULX || state == MULC;
   assign bus.y_out     = acc;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = bus.in_valid ? (n_cl == NW'(1) ? DONE : MULX) : IDLE;
         MULX:    state_nx = MULC;
         MULC:    state_nx = k == n - NW'(1) ? DONE : MULX;
         DONE:    state_nx = bus.out_ready ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t   <= '0;
         x   <= '0;
         acc <= '0;
         alt <= 1'b0;
         n   <= '0;
         k   <= '0;
      end else if (state == IDLE && bus.in_valid) begin
         t   <= ONE_T;
         x   <= bus.x_in;
         acc <= ONE_A;
         alt <= bus.alt_in;
         n   <= n_cl;
         k   <= NW'(1);
      end else if (state == MULX) begin
         t <= tn;
      end else if (state == MULC) begin
         t   <= tn;
         acc <= acc_nx;
         k   <= k + NW'(1);
      end
   end
   // entry 0 is never read: t_0 is the fixed 1.0 loaded on accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         coef[0] <= '0;
         for (int i = 1; i < TERMS; i++) coef[i] <= ONE_T / W'(i);
      end else if (bus.coef_we && !bus.busy) begin
         for (int i = 1; i < TERMS; i++)
            if (bus.coef_addr == AW'(i)) coef[i] <= bus.coef_wdata;
      end
   end
endmodule

// File: tb/tb_series_eval_engine.sv
// tb_series_eval_engine: scoreboard bench; expected results are queued at issue and compared on out_valid.
module tb_series_eval_engine;
   localparam int W     = 16;
   localparam int TERMS = 8;
   localparam int G     = 2;
   localparam int NW    = $clog2(TERMS) + 1;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   longint exp_q [$];
   longint coef_m [TERMS];
   series_eval_if #(.W(W), .TERMS(TERMS), .G(G)) bus ();
   series_eval_engine #(.W(W), .TERMS(TERMS), .G(G)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   initial begin
      #600000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end
   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic reset_model();
      coef_m[0] = 0;
      for (int i = 1; i < TERMS; i++) coef_m[i] = ((64'd1 << W) - 1) / i;
   endtask
   function automatic int clamp_n(input int n_in);
      return n_in < 1 ? 1 : (n_in > TERMS ? TERMS : n_in);
   endfunction
   function automatic longint model(input longint x, input bit alt, input int n_in);
      longint t   = (64'd1 << W) - 1;
      longint acc = 64'd1 << W;
      longint mx  = (64'd1 << (W + G)) - 1;
      for (int k = 1; k < clamp_n(n_in); k++) begin
         t = (t * x) >> W;
         t = (t * coef_m[k]) >> W;
         acc = (alt && (k % 2 == 1)) ? acc - t : acc + t;
         if (acc < 0) acc = 0;
         if (acc > mx) acc = mx;
      end
      return acc;
   endfunction
   task automatic wr(input int addr, input longint data);
      bus.coef_addr  = 3'(addr);
      bus.coef_wdata = W'(data);
      bus.coef_we    = 1'b1;
      tick();
      bus.coef_we = 1'b0;
      if (addr > 0 && addr < TERMS) coef_m[addr] = data;
   endtask
   task automatic op(input longint x, input bit alt, input int n_in, input longint exp_y,
                     input int hold, input bit poke, input string tag);
      int lat = 0;
      longint e;
      exp_q.push_back(exp_y);
      for (int i = 0; i < 50 && !bus.in_ready; i++) tick();
      check({tag, "_rdy"}, bus.in_ready, 1);
      bus.x_in       = W'(x);
      bus.alt_in     = alt;
      bus.n_terms_in = NW'(n_in);
      bus.in_valid   = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      lat = 1;
      if (poke) begin
         check({tag, "_busy"}, bus.busy, 1);
         bus.coef_we    = 1'b1;
         bus.coef_addr  = 3'd1;
         bus.coef_wdata = 16'd5;
         tick();
         bus.coef_we = 1'b0;
         lat++;
      end
      while (!bus.out_valid && lat < 100) begin
         tick();
         lat++;
      end
      check({tag, "_lat"}, lat, 2 * (clamp_n(n_in) - 1) + 1);
      e = exp_q.pop_front();
      check({tag, "_y"}, bus.y_out, e);
      if (hold > 0) begin
         bus.in_valid = 1'b1;
         bus.x_in     = ~W'(x);
         repeat (hold) begin
            tick();
            check({tag, "_hold_y"}, bus.y_out, e);
            check({tag, "_hold_inrdy"}, bus.in_ready, 0);
            check({tag, "_hold_ov"}, bus.out_valid, 1);
         end
         bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({tag, "_ov_clr"}, bus.out_valid, 0);
      if (hold > 0) check({tag, "_no_queue"}, bus.busy, 0);
   endtask
   initial begin
      bus.in_valid   = 1'b0;
      bus.x_in       = '0;
      bus.alt_in     = 1'b0;
      bus.n_terms_in = '0;
      bus.coef_we    = 1'b0;
      bus.coef_addr  = '0;
      bus.coef_wdata = '0;
      bus.out_ready  = 1'b0;
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      check("rst_inrdy", bus.in_ready, 1);
      check("rst_ov", bus.out_valid, 0);
      check("rst_y", bus.y_out, 0);
      check("rst_busy", bus.busy, 0);
      rst = 1'b0;
      tick();
      op(0, 0, 8, 65536, 0, 0, "x0n8");
      op(16'h8000, 0, 2, 98302, 0, 0, "half");
      op(16'h8000, 1, 2, 32770, 0, 0, "half_alt");
      op(16'h1234, 0, 0, 65536, 0, 0, "n0");
      op(16'h1234, 0, 15, model(16'h1234, 0, 15), 0, 0, "n15");
      repeat (6) begin
         longint rx = $urandom_range(0, 65535);
         bit ra = 1'($urandom_range(0, 1));
         int rn = $urandom_range(0, 15);
         op(rx, ra, rn, model(rx, ra, rn), 0, 0, "rand");
      end
      op(16'h4000, 1, 5, model(16'h4000, 1, 5), 10, 0, "bp");
      op(16'hC000, 0, 8, model(16'hC000, 0, 8), 0, 1, "poke");
      op(16'h8000, 0, 2, 98302, 0, 0, "after_poke");
      wr(0, 16'h1111);
      for (int i = 1; i < TERMS; i++) wr(i, 16'hFFFF);
      op(16'hFFFF, 0, 8, 262143, 0, 0, "sat");
      wr(1, 16'h4000);
      op(16'h8000, 0, 2, model(16'h8000, 0, 2), 0, 0, "a1w");
      bus.x_in       = 16'h8000;
      bus.alt_in     = 1'b0;
      bus.n_terms_in = NW'(8);
      bus.in_valid   = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      check("mid_busy", bus.busy, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_inrdy", bus.in_ready, 1);
      check("mid_rst_ov", bus.out_valid, 0);
      check("mid_rst_y", bus.y_out, 0);
      tick();
      check("mid_rst_busy", bus.busy, 0);
      rst = 1'b0;
      reset_model();
      tick();
      op(16'h8000, 0, 2, 98302, 0, 0, "post_rst");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
